jk_reg_bank: RTL and testbench
==============================

JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of JK bits in the bank (legal range 1..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the toggle-event counter (legal range 2..16).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous reset, active-low.
REQ-006 en  input  1  update enable; when 0, all state holds.
REQ-007 mode  input  2  operation select: JK, LOAD, SHIFT or HOLD.
REQ-008 J  input  WIDTH  per-bit J inputs.
REQ-009 K  input  WIDTH  per-bit K inputs.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 ser_in  input  1  serial input for SHIFT mode.
REQ-012 cnt_clr  input  1  synchronous clear of toggle_cnt.
REQ-013 Q  output  WIDTH  bank state.
REQ-014 Qn  output  WIDTH  bitwise complement of Q.
REQ-015 changed  output  1  registered flag: 1 for one cycle after any edge that changed Q.
REQ-016 toggle_cnt  output  CNT_W  saturating count of JK-mode toggle edges.
REQ-017 cnt_sat  output  1  1 while toggle_cnt equals all-ones.

Function
REQ-018 Q SHALL update only on a rising clk edge when reset=1 and en=1.
REQ-019 JK mode, per bit i, SHALL behave as follows: J=0,K=0 holds; J=1,K=0 sets 1; J=0,K=1 clears 0; J=1,K=1 toggles.
REQ-020 LOAD mode SHALL set Q to d.
REQ-021 SHIFT mode SHALL set Q to {Q[WIDTH-2:0], ser_in}; for WIDTH=1 it SHALL set Q to ser_in.
REQ-022 HOLD mode SHALL leave Q unchanged regardless of J, K and d.
REQ-023 Qn SHALL equal ~Q combinationally at all times, including during reset.
REQ-024 changed SHALL be registered and equal to 1 on the cycle after an edge where the next Q differed from the current Q, and 0 otherwise.
REQ-025 A toggle event SHALL be an enabled JK-mode edge with at least one bit where J&K=1; each such edge SHALL add exactly 1 to toggle_cnt, however many bits toggle.
REQ-026 toggle_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 cnt_clr=1 SHALL force toggle_cnt to 0 on the edge, even when en=0, and SHALL take priority over a simultaneous toggle event.
REQ-028 With en=0, Q, changed (forced to 0) and toggle_cnt SHALL hold; cnt_clr still applies.
REQ-029 Latency: every output change SHALL be visible one clk edge after its cause; the design SHALL have no combinational path from J, K, d or ser_in to Q.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for clk, force Q=0, Qn=all-ones, changed=0, toggle_cnt=0 and cnt_sat=0.
REQ-031 Reset SHALL take effect mid-operation in any mode; the first enabled edge after reset releases SHALL operate on Q=0.
REQ-032 Reset release SHALL be synchronised externally; the block SHALL NOT add a synchroniser.

Structure
REQ-033 A shared package jk_pkg SHALL hold the mode encodings MODE_JK=2'b00, MODE_LOAD=2'b01, MODE_SHIFT=2'b10 and MODE_HOLD=2'b11.
REQ-034 The package SHALL also hold a function that returns the next JK state for one bit.
REQ-035 A single-bit sub-module jk_cell (ports clk, reset, en, sel_jk, j, k, alt_d, q) SHALL be instantiated WIDTH times; the shift/load mux, counter and changed flag SHALL be in jk_reg_bank.

Verification
REQ-036 Reset and JK truth table: WIDTH=8; hold reset=0 for 12 ns -> Q=8'h00, Qn=8'hFF; then JK mode with J=8'hF0, K=8'h0F -> Q=8'hF0, changed=1; then J=K=8'hFF -> Q=8'h0F, toggle_cnt=1.
REQ-037 Load and shift: LOAD with d=8'hA5 -> Q=8'hA5; then SHIFT with ser_in=1 for 3 edges -> Q=8'h2F.
REQ-038 Hold and enable: HOLD mode or en=0 with J=K=8'hFF for 5 edges -> Q unchanged, changed=0, toggle_cnt unchanged.
REQ-039 Saturation: CNT_W=2; 5 toggle edges -> toggle_cnt=3, cnt_sat=1; cnt_clr together with a toggle edge -> toggle_cnt=0.
REQ-040 Asynchronous reset mid-operation: assert reset=0 between clk edges while Q=8'h5A -> Q=8'h00 before the next edge.
REQ-041 WIDTH=1 build: SHIFT with ser_in=1 -> Q=1; JK toggle -> Q=0.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: operation mode encodings and
// the single-bit JK next-state function.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  // Next state of one JK bit: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// Bus bundle for the JK register bank.
//   Controls (master -> slave): en, mode, J, K, d, ser_in, cnt_clr
//   Status   (slave -> master): Q, Qn, changed, toggle_cnt, cnt_sat
interface jk_reg_bank_if
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) ();

  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic             cnt_clr;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             changed;
  logic [CNT_W-1:0] toggle_cnt;
  logic             cnt_sat;

  modport master (
    output en, mode, J, K, d, ser_in, cnt_clr,
    input  Q, Qn, changed, toggle_cnt, cnt_sat
  );

  modport slave (
    input  en, mode, J, K, d, ser_in, cnt_clr,
    output Q, Qn, changed, toggle_cnt, cnt_sat
  );

endinterface

// File: rtl/jk_cell.sv
// One bit of the bank: a JK flop that can instead take an alternate data bit.
//   clk, reset (async, active-low), en (update enable)
//   sel_jk : 1 = JK behaviour, 0 = load alt_d
//   j, k, alt_d : per-bit inputs;  q : registered state
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sel_jk,
  input  logic j,
  input  logic k,
  input  logic alt_d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= sel_jk ? jk_next(q, j, k) : alt_d;
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK bits with load/shift/hold modes, a change flag and a
// saturating count of JK edges that toggled at least one bit.
//   clk, reset (async, active-low)
//   bus (slave): en, mode, J, K, d, ser_in, cnt_clr in;
//                Q, Qn (= ~Q), changed, toggle_cnt, cnt_sat out
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  jk_reg_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_alt;
  logic [WIDTH-1:0] w_jk_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_sel_jk;
  logic             w_toggle_evt;
  logic [CNT_W-1:0] w_cnt_next;

  logic             r_changed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_sat;

  // Shift-left source, ser_in enters at bit 0.
  generate
    if (WIDTH == 1) begin : g_shift_1
      assign w_shift = bus.ser_in;
    end else begin : g_shift_n
      assign w_shift = {w_q[WIDTH-2:0], bus.ser_in};
    end
  endgenerate

  // Mode decode and the alternate (non-JK) data for each cell.
  always_comb begin
    w_sel_jk = 1'b0;
    w_alt    = w_q;
    case (bus.mode)
      MODE_JK:    w_sel_jk = 1'b1;
      MODE_LOAD:  w_alt    = bus.d;
      MODE_SHIFT: w_alt    = w_shift;
      default:    w_alt    = w_q;
    endcase
  end

  // Predicted next Q, used only to detect a change for the changed flag.
  always_comb begin
    w_jk_next = w_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_jk_next[i] = jk_next(w_q[i], bus.J[i], bus.K[i]);
    end
    w_q_next = w_q;
    if (bus.en) begin
      w_q_next = w_sel_jk ? w_jk_next : w_alt;
    end
  end

  // One count per toggling JK edge regardless of how many bits toggle;
  // clear wins over increment and ignores en.
  always_comb begin
    w_toggle_evt = bus.en & w_sel_jk & (|(bus.J & bus.K));
    w_cnt_next   = r_cnt;
    if (bus.cnt_clr) begin
      w_cnt_next = '0;
    end else if (w_toggle_evt && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      jk_cell u_cell (
        .clk    (clk),
        .reset  (reset),
        .en     (bus.en),
        .sel_jk (w_sel_jk),
        .j      (bus.J[gi]),
        .k      (bus.K[gi]),
        .alt_d  (w_alt[gi]),
        .q      (w_q[gi])
      );
    end
  endgenerate

  // Status registers; changed drops to 0 on disabled edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_changed <= 1'b0;
      r_cnt     <= '0;
      r_cnt_sat <= 1'b0;
    end else begin
      r_changed <= bus.en & (w_q_next != w_q);
      r_cnt     <= w_cnt_next;
      r_cnt_sat <= (w_cnt_next == CNT_MAX);
    end
  end

  assign bus.Q          = w_q;
  assign bus.Qn         = ~w_q;
  assign bus.changed    = r_changed;
  assign bus.toggle_cnt = r_cnt;
  assign bus.cnt_sat    = r_cnt_sat;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: three builds (8/8, 8/2, 1/2) driven
// from a vector table, expected records queued at drive time and popped
// after the edge, plus hand-written reset sequences.
module tb_jk_reg_bank;
  import jk_pkg::*;

  logic clk;
  logic reset;

  jk_reg_bank_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  jk_reg_bank_if #(.WIDTH(8), .CNT_W(2)) buss ();
  jk_reg_bank_if #(.WIDTH(1), .CNT_W(2)) bus1 ();

  jk_reg_bank #(.WIDTH(8), .CNT_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  jk_reg_bank #(.WIDTH(8), .CNT_W(2)) u_duts (.clk(clk), .reset(reset), .bus(buss));
  jk_reg_bank #(.WIDTH(1), .CNT_W(2)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned sel;   // 0: 8/8 build, 1: 8/2 build, 2: 1-bit build
    mode_e       mode;
    logic        en;
    logic [7:0]  j;
    logic [7:0]  k;
    logic [7:0]  d;
    logic        ser;
    logic        clr;
    logic [7:0]  q;
    logic        ch;
    logic [7:0]  cnt;
    logic        sat;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(int unsigned sel, mode_e m, logic en,
                              logic [7:0] j, logic [7:0] k, logic [7:0] d,
                              logic ser, logic clr, logic [7:0] q, logic ch,
                              logic [7:0] cnt, logic sat);
    vec_t v;
    v.sel = sel; v.mode = m; v.en = en; v.j = j; v.k = k; v.d = d;
    v.ser = ser; v.clr = clr; v.q = q; v.ch = ch; v.cnt = cnt; v.sat = sat;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_all();
    bus8.en = 1'b0; bus8.mode = MODE_HOLD; bus8.J = '0; bus8.K = '0;
    bus8.d = '0; bus8.ser_in = 1'b0; bus8.cnt_clr = 1'b0;
    buss.en = 1'b0; buss.mode = MODE_HOLD; buss.J = '0; buss.K = '0;
    buss.d = '0; buss.ser_in = 1'b0; buss.cnt_clr = 1'b0;
    bus1.en = 1'b0; bus1.mode = MODE_HOLD; bus1.J = '0; bus1.K = '0;
    bus1.d = '0; bus1.ser_in = 1'b0; bus1.cnt_clr = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    idle_all();
    case (v.sel)
      0: begin
        bus8.en = v.en; bus8.mode = v.mode; bus8.J = v.j; bus8.K = v.k;
        bus8.d = v.d; bus8.ser_in = v.ser; bus8.cnt_clr = v.clr;
      end
      1: begin
        buss.en = v.en; buss.mode = v.mode; buss.J = v.j; buss.K = v.k;
        buss.d = v.d; buss.ser_in = v.ser; buss.cnt_clr = v.clr;
      end
      default: begin
        bus1.en = v.en; bus1.mode = v.mode; bus1.J = v.j[0:0]; bus1.K = v.k[0:0];
        bus1.d = v.d[0:0]; bus1.ser_in = v.ser; bus1.cnt_clr = v.clr;
      end
    endcase
    exp_q.push_back(v);
  endtask

  task automatic check_pop(input int idx);
    vec_t e;
    logic [7:0] gq, gqn, gcnt, eqn;
    logic gch, gsat;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty row=%0d got=0 exp=1", idx);
      return;
    end
    e = exp_q.pop_front();
    case (e.sel)
      0: begin
        gq = bus8.Q; gqn = bus8.Qn; gch = bus8.changed;
        gcnt = bus8.toggle_cnt; gsat = bus8.cnt_sat; eqn = ~e.q;
      end
      1: begin
        gq = buss.Q; gqn = buss.Qn; gch = buss.changed;
        gcnt = {6'b0, buss.toggle_cnt}; gsat = buss.cnt_sat; eqn = ~e.q;
      end
      default: begin
        gq = {7'b0, bus1.Q}; gqn = {7'b0, bus1.Qn}; gch = bus1.changed;
        gcnt = {6'b0, bus1.toggle_cnt}; gsat = bus1.cnt_sat;
        eqn = {7'b0, ~e.q[0]};
      end
    endcase
    cmp($sformatf("row%0d_Q", idx), 32'(gq), 32'(e.q));
    cmp($sformatf("row%0d_Qn", idx), 32'(gqn), 32'(eqn));
    cmp($sformatf("row%0d_changed", idx), 32'(gch), 32'(e.ch));
    cmp($sformatf("row%0d_toggle_cnt", idx), 32'(gcnt), 32'(e.cnt));
    cmp($sformatf("row%0d_cnt_sat", idx), 32'(gsat), 32'(e.sat));
  endtask

  task automatic check_reset_state(input string tag);
    cmp({tag, "_Q8"}, 32'(bus8.Q), 32'h00);
    cmp({tag, "_Qn8"}, 32'(bus8.Qn), 32'hFF);
    cmp({tag, "_changed8"}, 32'(bus8.changed), 32'h0);
    cmp({tag, "_cnt8"}, 32'(bus8.toggle_cnt), 32'h0);
    cmp({tag, "_sat8"}, 32'(bus8.cnt_sat), 32'h0);
    cmp({tag, "_Qs"}, 32'(buss.Q), 32'h00);
    cmp({tag, "_sats"}, 32'(buss.cnt_sat), 32'h0);
    cmp({tag, "_Q1"}, 32'(bus1.Q), 32'h0);
    cmp({tag, "_Qn1"}, 32'(bus1.Qn), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 8/8 build: JK truth table, load, shift, hold, enable, clear.
    tbl_a.push_back(mk(0, MODE_JK,    1, 8'hF0, 8'h0F, 8'h00, 0, 0, 8'hF0, 1, 8'd0, 0));
    tbl_a.push_back(mk(0, MODE_JK,    1, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'h0F, 1, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_LOAD,  1, 8'h00, 8'h00, 8'hA5, 0, 0, 8'hA5, 1, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_SHIFT, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h4B, 1, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_SHIFT, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h97, 1, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_SHIFT, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h2F, 1, 8'd1, 0));
    for (int i = 0; i < 3; i++)
      tbl_a.push_back(mk(0, MODE_HOLD, 1, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'h2F, 0, 8'd1, 0));
    for (int i = 0; i < 2; i++)
      tbl_a.push_back(mk(0, MODE_JK,   0, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'h2F, 0, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_JK,    1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h2F, 0, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_LOAD,  1, 8'h00, 8'h00, 8'h2F, 0, 0, 8'h2F, 0, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_JK,    1, 8'h00, 8'hFF, 8'h00, 0, 0, 8'h00, 1, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_JK,    0, 8'hFF, 8'hFF, 8'h00, 0, 1, 8'h00, 0, 8'd0, 0));
    tbl_a.push_back(mk(0, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h01, 1, 8'd1, 0));
    tbl_a.push_back(mk(0, MODE_JK,    1, 8'h03, 8'h03, 8'h00, 0, 0, 8'h02, 1, 8'd2, 0));
    tbl_a.push_back(mk(0, MODE_LOAD,  1, 8'h00, 8'h00, 8'h5A, 0, 0, 8'h5A, 1, 8'd2, 0));

    // After the mid-operation reset: first edge works on Q=0.
    tbl_b.push_back(mk(0, MODE_JK,    1, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'hFF, 1, 8'd1, 0));
    tbl_b.push_back(mk(0, MODE_JK,    0, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'hFF, 0, 8'd1, 0));
    // 8/2 build: saturation at 3, then clear beating a toggle edge.
    tbl_b.push_back(mk(1, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h01, 1, 8'd1, 0));
    tbl_b.push_back(mk(1, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h00, 1, 8'd2, 0));
    tbl_b.push_back(mk(1, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h01, 1, 8'd3, 1));
    tbl_b.push_back(mk(1, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h00, 1, 8'd3, 1));
    tbl_b.push_back(mk(1, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h01, 1, 8'd3, 1));
    tbl_b.push_back(mk(1, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 1, 8'h00, 1, 8'd0, 0));
    tbl_b.push_back(mk(1, MODE_JK,    0, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'h00, 0, 8'd0, 0));
    // 1-bit build.
    tbl_b.push_back(mk(2, MODE_SHIFT, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h01, 1, 8'd0, 0));
    tbl_b.push_back(mk(2, MODE_JK,    1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h00, 1, 8'd1, 0));
    tbl_b.push_back(mk(2, MODE_SHIFT, 1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'd1, 0));
    tbl_b.push_back(mk(2, MODE_LOAD,  1, 8'h00, 8'h00, 8'h01, 0, 0, 8'h01, 1, 8'd1, 0));
    tbl_b.push_back(mk(2, MODE_HOLD,  1, 8'h01, 8'h01, 8'h00, 0, 0, 8'h01, 0, 8'd1, 0));

    reset = 1'b0;
    idle_all();
    #11;
    check_reset_state("por");
    #1 reset = 1'b1;

    for (int i = 0; i < tbl_a.size(); i++) begin
      @(negedge clk);
      drive(tbl_a[i]);
      @(posedge clk);
      #1;
      check_pop(i);
    end

    // Asynchronous reset between edges while Q=8'h5A.
    @(negedge clk);
    idle_all();
    #2 reset = 1'b0;
    #1;
    check_reset_state("async");
    #1 reset = 1'b1;

    for (int i = 0; i < tbl_b.size(); i++) begin
      @(negedge clk);
      drive(tbl_b[i]);
      @(posedge clk);
      #1;
      check_pop(100 + i);
    end

    @(negedge clk);
    idle_all();
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
